// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - requester side of the two-wire req/gnt arbitration handshake
// Optional grant-wait timeout is built only when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
  parameter int LEN_W       = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             xfer_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             overflow,
  output logic             busy,
  output logic             timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic             empty, full, push, pop;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0]    wait_q, wait_d;
`endif

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign push       = start && (len != '0) && !full;
  assign xfer_valid = (state_q == XFER) && gnt;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;
    pop        = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
    timeout_d  = 1'b0;
    wait_d     = wait_q;
`else
    // Without the wait counter a job can never be abandoned.
    timeout_d  = (TIMEOUT_CYC < 0);
`endif

    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = REQ;
`ifdef ARB_REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      REQ: begin
        if (gnt) begin
          state_d    = XFER;
          pop        = 1'b1;
          beat_cnt_d = mem_q[rd_ptr_q];
        end
`ifdef ARB_REQ_TIMEOUT_EN
        // A grant on the expiry edge still wins over the timeout.
        else if (wait_q == WW'(TIMEOUT_CYC - 1)) begin
          state_d   = REL;
          pop       = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      XFER: begin
        if (gnt) begin
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d    = REL;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = len;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = start && (len != '0) && full;
    done_d     = (state_d == REL) && !timeout_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_q     <= wait_d;
`endif
    end
  end

  assign req      = (state_q == REQ) || (state_q == XFER);
  assign beat_cnt = beat_cnt_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - scoreboard bench for arb_requester
// Timeout scenario runs when ARB_REQ_TIMEOUT_EN is defined; otherwise an indefinite-wait scenario runs.
`timescale 1ns/1ps
module tb_arb_requester;

  localparam int LEN_W       = 4;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 8;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len   = '0;
  logic             gnt   = 1'b0;
  logic             req, xfer_valid, done, overflow, busy, timeout;
  logic [LEN_W-1:0] beat_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_beats[$];
  int exp_done[$];
  int beats_seen   = 0;
  int gap_cnt      = 0;
  bit gap_active   = 1'b0;
  int gaps_checked = 0;
  int sb_exp;

  always #5 clk = ~clk;

  arb_requester #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .gnt(gnt),
    .req(req), .xfer_valid(xfer_valid), .beat_cnt(beat_cnt), .done(done),
    .overflow(overflow), .busy(busy), .timeout(timeout)
  );

  // Scoreboard: pops an expected beat count per observed beat and an expected job length per done.
  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (xfer_valid === 1'b1) begin
        vectors++;
        if (exp_beats.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected: got beat_cnt=%0d, expected no beat", beat_cnt);
        end else begin
          sb_exp = exp_beats.pop_front();
          if (beat_cnt !== LEN_W'(sb_exp)) begin
            miscompares++;
            $display("FAIL beat_cnt: got %0d, expected %0d", beat_cnt, sb_exp);
          end
        end
        beats_seen++;
      end
      if (done === 1'b1) begin
        vectors++;
        if (exp_done.size() == 0) begin
          miscompares++;
          $display("FAIL done_unexpected: got done=1, expected 0");
          gap_active = 1'b0;
        end else begin
          sb_exp = exp_done.pop_front();
          if (beats_seen != sb_exp || req !== 1'b0) begin
            miscompares++;
            $display("FAIL done_job: got beats=%0d req=%b, expected beats=%0d req=0", beats_seen, req, sb_exp);
          end
          gap_active = (exp_done.size() != 0);
        end
        beats_seen = 0;
        gap_cnt    = 1;
      end else if (gap_active) begin
        if (req === 1'b0) begin
          gap_cnt++;
        end else begin
          vectors++;
          gaps_checked++;
          if (gap_cnt != 2) begin
            miscompares++;
            $display("FAIL req_gap: got %0d low cycles, expected 2", gap_cnt);
          end
          gap_active = 1'b0;
        end
      end
      if (reset === 1'b1) beats_seen = 0;
    end
  end

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; len = 4'd3; gnt = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_edge1: got req=%b busy=%b, expected 0 0", req, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_edge2: got req=%b busy=%b, expected 0 0", req, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({req, xfer_valid, beat_cnt, done, overflow, busy, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got req=%b xv=%b cnt=%0d done=%b ovf=%b busy=%b to=%b, expected all 0",
               req, xfer_valid, beat_cnt, done, overflow, busy, timeout);
    end
  endtask

  task automatic test_single;
    int n;
    @(posedge clk); #1;
    start = 1'b1; len = 4'd3; gnt = 1'b1;
    exp_beats.push_back(3); exp_beats.push_back(2); exp_beats.push_back(1);
    exp_done.push_back(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (req !== 1'b0) begin
      miscompares++;
      $display("FAIL single_req_early: got req=%b, expected 0", req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (req !== 1'b1) begin
      miscompares++;
      $display("FAIL single_req_rise: got req=%b, expected 1", req);
    end
    n = 0;
    while (n < 40 && exp_done.size() != 0) begin @(posedge clk); n++; end
    #1;
    vectors++;
    if (exp_done.size() != 0 || exp_beats.size() != 0) begin
      miscompares++;
      $display("FAIL single_complete: got %0d beats %0d dones pending, expected 0 0", exp_beats.size(), exp_done.size());
    end
    @(negedge clk);
    vectors++;
    if (req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after: got req=%b done=%b busy=%b, expected 0 0 0", req, done, busy);
    end
  endtask

  task automatic test_pause;
    int n;
    @(posedge clk); #1;
    start = 1'b1; len = 4'd3; gnt = 1'b1;
    exp_beats.push_back(3); exp_beats.push_back(2); exp_beats.push_back(1);
    exp_done.push_back(3);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 20 && xfer_valid !== 1'b1) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL pause_first_beat: got no beat in %0d cycles, expected one", n);
    end
    @(posedge clk); #1;
    gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (req !== 1'b1 || xfer_valid !== 1'b0 || beat_cnt !== 4'd2) begin
        miscompares++;
        $display("FAIL pause_gap%0d: got req=%b xv=%b cnt=%0d, expected 1 0 2", i, req, xfer_valid, beat_cnt);
      end
      @(posedge clk); #1;
    end
    gnt = 1'b1;
    n = 0;
    while (n < 40 && exp_done.size() != 0) begin @(posedge clk); n++; end
    #1;
    vectors++;
    if (exp_done.size() != 0 || exp_beats.size() != 0) begin
      miscompares++;
      $display("FAIL pause_complete: got %0d beats %0d dones pending, expected 0 0", exp_beats.size(), exp_done.size());
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || req !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_after: got done=%b req=%b, expected 0 0", done, req);
    end
  endtask

  task automatic test_fifo_full;
    int n;
    int gaps_before;
    gaps_before = gaps_checked;
    gnt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      start = 1'b1; len = LEN_W'(i);
      if (i <= DEPTH) begin
        for (int b = i; b >= 1; b--) exp_beats.push_back(b);
        exp_done.push_back(i);
      end
      @(negedge clk);
      vectors++;
      if (overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL fifo_ovf_early%0d: got overflow=%b, expected 0", i, overflow);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b1 || busy !== 1'b1 || req !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_ovf_pulse: got ovf=%b busy=%b req=%b, expected 1 1 1", overflow, busy, req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_ovf_width: got overflow=%b, expected 0", overflow);
    end
    n = 0;
    while (n < 100 && exp_done.size() != 0) begin @(posedge clk); n++; end
    #1;
    vectors++;
    if (exp_done.size() != 0 || exp_beats.size() != 0 || gaps_checked != gaps_before + 3) begin
      miscompares++;
      $display("FAIL fifo_jobs: got %0d beats %0d dones pending %0d gaps, expected 0 0 3",
               exp_beats.size(), exp_done.size(), gaps_checked - gaps_before);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_idle: got busy=%b, expected 0", busy);
    end
  endtask

`ifdef ARB_REQ_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    int hi;
    gnt = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; hi = 0;
    while (n < 40 && timeout !== 1'b1) begin
      @(negedge clk);
      if (req === 1'b1) hi++;
      n++;
    end
    vectors++;
    if (timeout !== 1'b1 || hi != TIMEOUT_CYC || done !== 1'b0 || req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_fire: got to=%b req_cycles=%0d done=%b req=%b, expected 1 %0d 0 0",
               timeout, hi, done, req, TIMEOUT_CYC);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || timeout !== 1'b0 || req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_after: got busy=%b to=%b req=%b, expected 0 0 0", busy, timeout, req);
    end
  endtask
`else
  task automatic test_no_timeout;
    int n;
    int hi;
    bit seen_to;
    gnt = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len = 4'd2;
    exp_beats.push_back(2); exp_beats.push_back(1);
    exp_done.push_back(2);
    @(posedge clk); #1;
    start = 1'b0;
    hi = 0; seen_to = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (timeout !== 1'b0) seen_to = 1'b1;
      if (req === 1'b1) hi++;
    end
    vectors++;
    if (hi != 19 || seen_to) begin
      miscompares++;
      $display("FAIL wait_forever: got req_cycles=%0d timeout_seen=%b, expected 19 0", hi, seen_to);
    end
    @(posedge clk); #1;
    gnt = 1'b1;
    n = 0;
    while (n < 40 && exp_done.size() != 0) begin @(posedge clk); n++; end
    #1;
    vectors++;
    if (exp_done.size() != 0 || exp_beats.size() != 0) begin
      miscompares++;
      $display("FAIL wait_complete: got %0d beats %0d dones pending, expected 0 0", exp_beats.size(), exp_done.size());
    end
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; len = 4'd4;
    for (int b = 4; b >= 1; b--) exp_beats.push_back(b);
    exp_done.push_back(4);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 20 && !(xfer_valid === 1'b1 && beat_cnt === 4'd4)) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL rmid_first_beat: got no beat in %0d cycles, expected one", n);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_beats.delete();
    exp_done.delete();
    @(negedge clk);
    vectors++;
    if ({req, xfer_valid, busy, done, beat_cnt} !== '0) begin
      miscompares++;
      $display("FAIL rmid_clear: got req=%b xv=%b busy=%b done=%b cnt=%0d, expected all 0",
               req, xfer_valid, busy, done, beat_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || xfer_valid !== 1'b0 || req !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_quiet: got done=%b xv=%b req=%b, expected 0 0 0", done, xfer_valid, req);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    miscompares++;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_single();
    test_pause();
    test_fifo_full();
`ifdef ARB_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
